// File: rtl/mgt_01_fp_mag_arbiter_pkg.sv
// mgt_01_fp_mag_arbiter_pkg
// Shared types for the FP magnitude arbiter slice:
//   float_t      - IEEE-754 single-precision word
//   fcmp_ops     - magnitude operation select (FMIN_ / FMAX_)
//   mag_result_t - one result-buffer entry: data, requester id, flags
package mgt_01_fp_mag_arbiter_pkg;

    typedef logic [31:0] float_t;

    typedef enum logic {
        FMIN_ = 1'b0,
        FMAX_ = 1'b1
    } fcmp_ops;

    // The id field is sized for the largest legal requester count (4), so a
    // single entry layout serves every arbiter configuration.
    localparam int MAG_ID_W   = 2;
    localparam int MAG_FLAG_W = 3;

    // flags = {invalid, overflow, underflow}
    typedef struct packed {
        float_t                data;
        logic [MAG_ID_W-1:0]   id;
        logic [MAG_FLAG_W-1:0] flags;
    } mag_result_t;

    localparam int MAG_RESULT_W = $bits(mag_result_t);

endpackage

// File: rtl/mgt_01_sync_fifo.sv
// mgt_01_sync_fifo
// Small synchronous FIFO that buffers magnitude-unit results.
// Ports:
//   clk_i, rst_n_i   - clock, synchronous active-low reset
//   flush_i          - empty the FIFO (pointers and count to zero)
//   push_i, wdata_i  - write request and data
//   pop_i            - read request; rdata_o shows the head entry
//   empty_o, count_o - occupancy status
// Storage is not reset; only the pointers and count are.
module mgt_01_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is still legal when a pop frees the slot in
    // the same cycle; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        doPop   = pop_i && (count_q != '0);
        doPush  = push_i && !flush_i && ((count_q != FULL_COUNT) || doPop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (doPush) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (doPop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Control state; flush behaves like a reset of the bookkeeping only.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Data storage, deliberately without reset.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mgt_01_fp_mag_arbiter.sv
// mgt_01_fp_mag_arbiter
// Round-robin arbiter that shares one external FP magnitude (min/max) unit
// between N_REQ requesters and returns results, tagged with the requester
// id, through an in-order result FIFO.
// Ports:
//   clk_i, rst_n_i                      - clock, synchronous active-low reset
//   flush_i                             - drop in-flight op and buffered results
//   req_valid_i / req_ready_o           - per-requester handshake
//   req_op_a_i, req_op_b_i, req_op_i    - per-requester operands and op
//   mag_op_a_o, mag_op_b_o, mag_op_o    - granted operands to the unit
//   mag_clk_en_o                        - unit stage enable (= accept)
//   mag_result_i, mag_*_i flags         - unit result one cycle after accept
//   res_valid_o / res_ready_i           - result handshake
//   res_data_o, res_id_o, res_flags_o   - result, origin, {inv, ovf, unf}
// Accept-to-result latency is 2 cycles with an empty FIFO.
module mgt_01_fp_mag_arbiter
    import mgt_01_fp_mag_arbiter_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  float_t [N_REQ-1:0]         req_op_a_i,
    input  float_t [N_REQ-1:0]         req_op_b_i,
    input  fcmp_ops [N_REQ-1:0]        req_op_i,
    output float_t                     mag_op_a_o,
    output float_t                     mag_op_b_o,
    output fcmp_ops                    mag_op_o,
    output logic                       mag_clk_en_o,
    input  float_t                     mag_result_i,
    input  logic                       mag_invalid_i,
    input  logic                       mag_overflow_i,
    input  logic                       mag_underflow_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output float_t                     res_data_o,
    output logic [$clog2(N_REQ)-1:0]   res_id_o,
    output logic [2:0]                 res_flags_o
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           inFlight_q, inFlight_d;
    logic [IDW-1:0] inFlightId_q, inFlightId_d;

    logic [IDW-1:0] gntIdx;
    logic           gntFound;
    int             scanIdx;
    logic           grantEn;
    logic           accept;
    logic           pop;
    logic           push;
    logic           fifoEmpty;
    logic [CW-1:0]  fifoCount;
    mag_result_t    wrEntry;
    mag_result_t    rdEntry;
    logic           id_unused;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        gntFound = 1'b0;
        gntIdx   = ptr_q;
        scanIdx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scanIdx = int'(ptr_q) + i;
            if (scanIdx >= N_REQ) begin
                scanIdx = scanIdx - N_REQ;
            end
            if (!gntFound && req_valid_i[scanIdx]) begin
                gntFound = 1'b1;
                gntIdx   = IDW'(scanIdx);
            end
        end
    end

    // Occupancy counts the in-flight op as already buffered and credits a
    // same-cycle pop, so the FIFO can never be overrun by the push one
    // cycle later. Reset and flush both block granting.
    assign pop     = res_valid_o && res_ready_i;
    assign grantEn = rst_n_i && !flush_i &&
                     ((int'(fifoCount) + int'(inFlight_q) - int'(pop)) < FIFO_DEPTH);
    assign accept  = grantEn && gntFound;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = accept && (gntIdx == IDW'(i));
        end
    end

    assign mag_op_a_o   = req_op_a_i[gntIdx];
    assign mag_op_b_o   = req_op_b_i[gntIdx];
    assign mag_op_o     = req_op_i[gntIdx];
    assign mag_clk_en_o = accept;

    // Next-state: pointer moves past the winner only on an accept; the
    // in-flight bit tracks last cycle's accept (accept is already low
    // during flush, which is what discards the pending push).
    always_comb begin
        ptr_d        = ptr_q;
        inFlight_d   = accept;
        inFlightId_d = inFlightId_q;
        if (accept) begin
            ptr_d        = (gntIdx == IDW'(N_REQ - 1)) ? '0 : gntIdx + IDW'(1);
            inFlightId_d = gntIdx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q        <= '0;
            inFlight_q   <= 1'b0;
            inFlightId_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            inFlight_q   <= inFlight_d;
            inFlightId_q <= inFlightId_d;
        end
    end

    // The unit result arrives the cycle after the accept and is captured
    // together with the id that was latched at accept time.
    assign push = inFlight_q && !flush_i;

    always_comb begin
        wrEntry       = '0;
        wrEntry.data  = mag_result_i;
        wrEntry.id    = MAG_ID_W'(inFlightId_q);
        wrEntry.flags = {mag_invalid_i, mag_overflow_i, mag_underflow_i};
    end

    mgt_01_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MAG_RESULT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push),
        .wdata_i (wrEntry),
        .pop_i   (pop),
        .rdata_o (rdEntry),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign res_valid_o = rst_n_i && !fifoEmpty;
    assign res_data_o  = rdEntry.data;
    assign res_id_o    = rdEntry.id[IDW-1:0];
    assign res_flags_o = rdEntry.flags;

    // Upper id bits are only meaningful for larger requester counts.
    assign id_unused = ^rdEntry.id;

endmodule

// File: tb/tb_mgt_01_fp_mag_arbiter.sv
// tb_mgt_01_fp_mag_arbiter
// Directed bench for the FP magnitude arbiter (N_REQ=2, FIFO_DEPTH=2).
// Includes a behavioural stand-in for the external magnitude unit that
// registers its result one cycle after mag_clk_en_o.
module tb_mgt_01_fp_mag_arbiter;
    import mgt_01_fp_mag_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          rstN;
    logic          flush;
    logic [1:0]    reqValid;
    logic [1:0]    reqReady;
    float_t [1:0]  reqOpA;
    float_t [1:0]  reqOpB;
    fcmp_ops [1:0] reqOp;
    float_t        magOpA;
    float_t        magOpB;
    fcmp_ops       magOp;
    logic          magClkEn;
    float_t        magResult = '0;
    logic          magInvalid = 1'b0;
    logic          resValid;
    logic          resReady;
    float_t        resData;
    logic [0:0]    resId;
    logic [2:0]    resFlags;

    float_t        pendA [2];
    float_t        pendB [2];
    fcmp_ops       pendOp [2];

    int vecCount  = 0;
    int missCount = 0;

    mgt_01_fp_mag_arbiter #(
        .N_REQ      (2),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rstN),
        .flush_i         (flush),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_op_a_i      (reqOpA),
        .req_op_b_i      (reqOpB),
        .req_op_i        (reqOp),
        .mag_op_a_o      (magOpA),
        .mag_op_b_o      (magOpB),
        .mag_op_o        (magOp),
        .mag_clk_en_o    (magClkEn),
        .mag_result_i    (magResult),
        .mag_invalid_i   (magInvalid),
        .mag_overflow_i  (1'b0),
        .mag_underflow_i (1'b0),
        .res_valid_o     (resValid),
        .res_ready_i     (resReady),
        .res_data_o      (resData),
        .res_id_o        (resId),
        .res_flags_o     (resFlags)
    );

    always #5 clk = ~clk;

    // Stand-in magnitude unit: returns {invalid, result}. A single NaN
    // operand yields the other operand; a signalling NaN raises invalid.
    function automatic logic [32:0] fmag(input float_t a, input float_t b, input fcmp_ops op);
        logic   aNan;
        logic   bNan;
        logic   inv;
        logic   aLt;
        float_t r;
        aNan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bNan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inv  = (aNan && !a[22]) || (bNan && !b[22]);
        if (a[31] != b[31]) begin
            aLt = a[31];
        end else if (!a[31]) begin
            aLt = a[30:0] < b[30:0];
        end else begin
            aLt = a[30:0] > b[30:0];
        end
        if (aNan && bNan) begin
            r = 32'h7FC00000;
        end else if (aNan) begin
            r = b;
        end else if (bNan) begin
            r = a;
        end else if (op == FMIN_) begin
            r = aLt ? a : b;
        end else begin
            r = aLt ? b : a;
        end
        return {inv, r};
    endfunction

    always @(posedge clk) begin
        if (magClkEn) begin
            {magInvalid, magResult} <= fmag(magOpA, magOpB, magOp);
        end
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Queue requester fields; they reach the DUT with the next stimulus.
    task automatic setReq(input int idx, input float_t a, input float_t b, input fcmp_ops op);
        pendA[idx]  = a;
        pendB[idx]  = b;
        pendOp[idx] = op;
    endtask

    // One cycle: drive just after the rising edge, return at the falling
    // edge where the caller samples outputs.
    task automatic applyStimulus(input logic [1:0] valid, input logic rdy, input logic fl, input logic rn);
        @(posedge clk);
        #1;
        reqValid  = valid;
        resReady  = rdy;
        flush     = fl;
        rstN      = rn;
        reqOpA[0] = pendA[0];
        reqOpA[1] = pendA[1];
        reqOpB[0] = pendB[0];
        reqOpB[1] = pendB[1];
        reqOp[0]  = pendOp[0];
        reqOp[1]  = pendOp[1];
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expRdy;
        int         expId;
        float_t     expData;

        rstN     = 1'b0;
        flush    = 1'b0;
        reqValid = '0;
        resReady = 1'b0;
        reqOpA   = '0;
        reqOpB   = '0;
        reqOp    = {FMIN_, FMIN_};
        setReq(0, 32'h0, 32'h0, FMIN_);
        setReq(1, 32'h0, 32'h0, FMIN_);

        // Reset held with requests pending: everything stays quiet.
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_ready", 64'(reqReady), 64'h0);
        checkOutput("rst_magen", 64'(magClkEn), 64'h0);
        checkOutput("rst_resvalid", 64'(resValid), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);

        // Single FMIN from requester 0, 2-cycle latency.
        setReq(0, 32'h3F800000, 32'h40000000, FMIN_);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
        checkOutput("single_ready", 64'(reqReady), 64'h1);
        checkOutput("single_magen", 64'(magClkEn), 64'h1);
        checkOutput("single_mag_a", 64'(magOpA), 64'h3F800000);
        checkOutput("single_mag_b", 64'(magOpB), 64'h40000000);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("single_valid_t1", 64'(resValid), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("single_valid_t2", 64'(resValid), 64'h1);
        checkOutput("single_data", 64'(resData), 64'h3F800000);
        checkOutput("single_id", 64'(resId), 64'h0);
        checkOutput("single_flags", 64'(resFlags), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("single_valid_t3", 64'(resValid), 64'h0);

        // Reset, then both requesters always valid: strict alternation.
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        setReq(0, 32'h40400000, 32'h40800000, FMAX_);
        setReq(1, 32'hC0000000, 32'h3F800000, FMIN_);
        for (int c = 0; c < 7; c++) begin
            applyStimulus((c < 4) ? 2'b11 : 2'b00, 1'b1, 1'b0, 1'b1);
            expRdy = (c < 4) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checkOutput($sformatf("rr_ready_c%0d", c), 64'(reqReady), 64'(expRdy));
            if (c >= 2 && c < 6) begin
                expId   = (c - 2) % 2;
                expData = (expId == 1) ? 32'hC0000000 : 32'h40800000;
                checkOutput($sformatf("rr_valid_c%0d", c), 64'(resValid), 64'h1);
                checkOutput($sformatf("rr_id_c%0d", c), 64'(resId), 64'(expId));
                checkOutput($sformatf("rr_data_c%0d", c), 64'(resData), 64'(expData));
            end else begin
                checkOutput($sformatf("rr_valid_c%0d", c), 64'(resValid), 64'h0);
            end
        end

        // Back-pressure: two accepted, third held off until a slot frees.
        setReq(0, 32'h40A00000, 32'h40C00000, FMIN_);
        setReq(1, 32'h41000000, 32'h40E00000, FMAX_);
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready_c0", 64'(reqReady), 64'h1);
        setReq(0, 32'hC1200000, 32'h41200000, FMAX_);
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready_c1", 64'(reqReady), 64'h2);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready_c2", 64'(reqReady), 64'h0);
        checkOutput("bp_valid_c2", 64'(resValid), 64'h1);
        checkOutput("bp_id_c2", 64'(resId), 64'h0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready_c3", 64'(reqReady), 64'h0);
        checkOutput("bp_data_c3", 64'(resData), 64'h40A00000);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_ready_c4", 64'(reqReady), 64'h0);
        checkOutput("bp_hold_c4", 64'(resData), 64'h40A00000);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_ready_c5", 64'(reqReady), 64'h1);
        checkOutput("bp_data_c5", 64'(resData), 64'h40A00000);
        checkOutput("bp_id_c5", 64'(resId), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_valid_c6", 64'(resValid), 64'h1);
        checkOutput("bp_id_c6", 64'(resId), 64'h1);
        checkOutput("bp_data_c6", 64'(resData), 64'h41000000);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_valid_c7", 64'(resValid), 64'h1);
        checkOutput("bp_id_c7", 64'(resId), 64'h0);
        checkOutput("bp_data_c7", 64'(resData), 64'h41200000);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_valid_c8", 64'(resValid), 64'h0);

        // Signalling NaN operand: other operand returned, invalid raised.
        setReq(1, 32'hFF800001, 32'h3F800000, FMIN_);
        applyStimulus(2'b10, 1'b1, 1'b0, 1'b1);
        checkOutput("snan_ready", 64'(reqReady), 64'h2);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("snan_valid", 64'(resValid), 64'h1);
        checkOutput("snan_data", 64'(resData), 64'h3F800000);
        checkOutput("snan_id", 64'(resId), 64'h1);
        checkOutput("snan_flags", 64'(resFlags), 64'h4);

        // Flush with one result buffered and one in flight.
        setReq(0, 32'h40000000, 32'h40400000, FMAX_);
        setReq(1, 32'h40800000, 32'h40A00000, FMIN_);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_ready_e0", 64'(reqReady), 64'h1);
        applyStimulus(2'b10, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_ready_e1", 64'(reqReady), 64'h2);
        checkOutput("fl_valid_e1", 64'(resValid), 64'h0);
        setReq(0, 32'hBF800000, 32'h3F800000, FMIN_);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b1);
        checkOutput("fl_ready_e2", 64'(reqReady), 64'h0);
        checkOutput("fl_magen_e2", 64'(magClkEn), 64'h0);
        checkOutput("fl_valid_e2", 64'(resValid), 64'h1);
        checkOutput("fl_data_e2", 64'(resData), 64'h40400000);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_valid_e3", 64'(resValid), 64'h0);
        checkOutput("fl_ready_e3", 64'(reqReady), 64'h1);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_valid_e4", 64'(resValid), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_valid_e5", 64'(resValid), 64'h1);
        checkOutput("fl_data_e5", 64'(resData), 64'hBF800000);
        checkOutput("fl_id_e5", 64'(resId), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("fl_valid_e6", 64'(resValid), 64'h0);

        // One-cycle reset mid-stream: work discarded, pointer back to 0.
        setReq(0, 32'h41100000, 32'h41200000, FMIN_);
        setReq(1, 32'h40000000, 32'h3F800000, FMAX_);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_ready_f0", 64'(reqReady), 64'h2);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_ready_f1", 64'(reqReady), 64'h1);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        checkOutput("mr_ready_f2", 64'(reqReady), 64'h0);
        checkOutput("mr_magen_f2", 64'(magClkEn), 64'h0);
        checkOutput("mr_valid_f2", 64'(resValid), 64'h0);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_ready_f3", 64'(reqReady), 64'h1);
        checkOutput("mr_valid_f3", 64'(resValid), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_valid_f4", 64'(resValid), 64'h0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_valid_f5", 64'(resValid), 64'h1);
        checkOutput("mr_id_f5", 64'(resId), 64'h0);
        checkOutput("mr_data_f5", 64'(resData), 64'h41100000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
